// File: rtl/sr_bank_arbiter.sv
// sr_bank_arbiter
//   Round-robin arbiter and sequencer for a shared bank of NBITS set/reset bits.
//   Each requester posts a set/reset command for one bit of the bank. One command
//   is granted at a time and applied to the bank. The illegal S=R=1 condition
//   is never applied: such commands, and commands with an out-of-range index,
//   are granted with err and leave the bank unchanged.
//
//   State | meaning
//   IDLE  | waiting for a request; arbitrates and latches the winning command
//   APPLY | applies the latched command to q, raises gnt/err, advances ptr
//   ACK   | gnt/err high for this one cycle; requests are ignored
//
// Ports
//   clk      in   1           clock, rising edge
//   rst      in   1           synchronous reset, active-low
//   req      in   NREQ        per-requester request
//   cmd_s    in   NREQ        per-requester set input
//   cmd_r    in   NREQ        per-requester reset input
//   cmd_idx  in   NREQ*IDXW   per-requester target bit, requester i at [i*IDXW +: IDXW]
//   gnt      out  NREQ        one-hot grant, one cycle per command
//   err      out  1           command rejected (valid with gnt)
//   busy     out  1           state != IDLE
//   q        out  NBITS       bank state, registered
//   qb       out  NBITS       ~q
module sr_bank_arbiter #(
    parameter int NREQ  = 4,
    parameter int NBITS = 8,
    parameter int IDXW  = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ-1:0]      cmd_s,
    input  logic [NREQ-1:0]      cmd_r,
    input  logic [NREQ*IDXW-1:0] cmd_idx,
    output logic [NREQ-1:0]      gnt,
    output logic                 err,
    output logic                 busy,
    output logic [NBITS-1:0]     q,
    output logic [NBITS-1:0]     qb
);

    localparam int PW = $clog2(NREQ);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        APPLY = 2'd1,
        ACK   = 2'd2
    } state_t;

    state_t          state, state_nxt;
    logic [PW-1:0]   ptr, ptr_nxt;
    logic [PW-1:0]   lat_win, lat_win_nxt;
    logic            lat_s, lat_s_nxt;
    logic            lat_r, lat_r_nxt;
    logic [IDXW-1:0] lat_idx, lat_idx_nxt;
    logic [NREQ-1:0] gnt_nxt;
    logic            err_nxt;
    logic [NBITS-1:0] q_nxt;

    logic [PW-1:0]   win_idx;
    logic            win_found;
    logic            cmd_bad;

    // First requester at or above ptr, wrapping; this rotation bounds the wait
    // of any requester to NREQ arbitrations.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!win_found && req[(int'(ptr) + k) % NREQ]) begin
                win_found = 1'b1;
                win_idx   = PW'((int'(ptr) + k) % NREQ);
            end
        end
    end

    assign cmd_bad = (lat_s && lat_r) || (int'(lat_idx) >= NBITS);

    always_comb begin
        state_nxt   = state;
        ptr_nxt     = ptr;
        lat_win_nxt = lat_win;
        lat_s_nxt   = lat_s;
        lat_r_nxt   = lat_r;
        lat_idx_nxt = lat_idx;
        gnt_nxt     = '0;
        err_nxt     = 1'b0;
        q_nxt       = q;
        case (state)
            IDLE: begin
                if (win_found) begin
                    lat_win_nxt = win_idx;
                    lat_s_nxt   = cmd_s[win_idx];
                    lat_r_nxt   = cmd_r[win_idx];
                    lat_idx_nxt = cmd_idx[int'(win_idx)*IDXW +: IDXW];
                    state_nxt   = APPLY;
                end
            end
            APPLY: begin
                gnt_nxt[lat_win] = 1'b1;
                err_nxt          = cmd_bad;
                // Rejected commands still advance ptr so a faulty requester
                // cannot monopolise the bank.
                if (!cmd_bad) begin
                    if (lat_s) begin
                        q_nxt[lat_idx] = 1'b1;
                    end else if (lat_r) begin
                        q_nxt[lat_idx] = 1'b0;
                    end
                end
                ptr_nxt   = (lat_win == PW'(NREQ - 1)) ? '0 : lat_win + 1'b1;
                state_nxt = ACK;
            end
            ACK: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= IDLE;
            ptr     <= '0;
            lat_win <= '0;
            lat_s   <= 1'b0;
            lat_r   <= 1'b0;
            lat_idx <= '0;
            gnt     <= '0;
            err     <= 1'b0;
            q       <= '0;
        end else begin
            state   <= state_nxt;
            ptr     <= ptr_nxt;
            lat_win <= lat_win_nxt;
            lat_s   <= lat_s_nxt;
            lat_r   <= lat_r_nxt;
            lat_idx <= lat_idx_nxt;
            gnt     <= gnt_nxt;
            err     <= err_nxt;
            q       <= q_nxt;
        end
    end

    assign busy = (state != IDLE);
    assign qb   = ~q;

endmodule

// File: tb/tb_sr_bank_arbiter.sv
// tb_sr_bank_arbiter
//   Self-checking bench for sr_bank_arbiter. One instance uses the default
//   8-bit bank, a second one a 6-bit bank for the out-of-range index case.
//   Expected grant/err/q triples are queued when a command is posted and
//   compared when the grant appears.
module tb_sr_bank_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  req, cmd_s, cmd_r;
    logic [11:0] cmd_idx;
    logic [3:0]  gnt;
    logic        err, busy;
    logic [7:0]  q, qb;

    logic [3:0]  req6, cmd_s6, cmd_r6;
    logic [11:0] cmd_idx6;
    logic [3:0]  gnt6;
    logic        err6, busy6;
    logic [5:0]  q6, qb6;

    sr_bank_arbiter #(.NREQ(4), .NBITS(8), .IDXW(3)) dut (
        .clk(clk), .rst(rst), .req(req), .cmd_s(cmd_s), .cmd_r(cmd_r),
        .cmd_idx(cmd_idx), .gnt(gnt), .err(err), .busy(busy), .q(q), .qb(qb)
    );

    sr_bank_arbiter #(.NREQ(4), .NBITS(6), .IDXW(3)) dut6 (
        .clk(clk), .rst(rst), .req(req6), .cmd_s(cmd_s6), .cmd_r(cmd_r6),
        .cmd_idx(cmd_idx6), .gnt(gnt6), .err(err6), .busy(busy6), .q(q6), .qb(qb6)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] gnt;
        logic       err;
        logic [7:0] q;
    } exp_t;

    exp_t sb[$];
    int   n_pass  = 0;
    int   n_total = 0;
    logic [7:0] m_q;
    int   m_ptr;

    function automatic int rr_pick(logic [3:0] r, int p);
        for (int k = 0; k < 4; k++) begin
            if (r[(p + k) % 4]) return (p + k) % 4;
        end
        return -1;
    endfunction

    task automatic set_cmd(int i, bit s, bit r, int idx);
        logic [2:0] ix;
        ix = idx[2:0];
        cmd_s[i] = s;
        cmd_r[i] = r;
        cmd_idx[i*3 +: 3] = ix;
    endtask

    task automatic push_exp(int w, bit s, bit r, int idx);
        exp_t e;
        bit   bad;
        bad = (s && r) || (idx >= 8);
        if (!bad) begin
            if (s) m_q[idx] = 1'b1;
            else if (r) m_q[idx] = 1'b0;
        end
        e.gnt = 4'b0001 << w;
        e.err = bad;
        e.q   = m_q;
        m_ptr = (w + 1) % 4;
        sb.push_back(e);
    endtask

    task automatic wait_gnt(output bit ok, output int cyc);
        ok  = 1'b0;
        cyc = 0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk);
            #1;
            if (gnt !== 4'b0000) begin
                ok  = 1'b1;
                cyc = c + 1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; req = '0; cmd_s = '0; cmd_r = '0; cmd_idx = '0;
        req6 = '0; cmd_s6 = '0; cmd_r6 = '0; cmd_idx6 = '0;
        repeat (2) @(posedge clk);
        #1;
        n_total++;
        if (q !== 8'h00) $display("FAIL reset_hold_q got=%h exp=00", q); else n_pass++;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        n_total++;
        if (q !== 8'h00) $display("FAIL reset_q got=%h exp=00", q); else n_pass++;
        n_total++;
        if (qb !== 8'hFF) $display("FAIL reset_qb got=%h exp=ff", qb); else n_pass++;
        n_total++;
        if (gnt !== 4'b0000) $display("FAIL reset_gnt got=%b exp=0000", gnt); else n_pass++;
        n_total++;
        if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else n_pass++;
        n_total++;
        if (err !== 1'b0) $display("FAIL reset_err got=%b exp=0", err); else n_pass++;
        m_q   = 8'h00;
        m_ptr = 0;
    endtask

    task automatic test_single_set();
        exp_t e;
        @(negedge clk);
        set_cmd(0, 1, 0, 3);
        req[0] = 1'b1;
        push_exp(rr_pick(req, m_ptr), 1, 0, 3);
        @(posedge clk);
        #1;
        n_total++;
        if (busy !== 1'b1) $display("FAIL single_busy_apply got=%b exp=1", busy); else n_pass++;
        n_total++;
        if (gnt !== 4'b0000) $display("FAIL single_gnt_early got=%b exp=0000", gnt); else n_pass++;
        @(negedge clk);
        // Changing the inputs after the latch edge must not affect this command.
        req[0] = 1'b0;
        set_cmd(0, 0, 1, 3);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        n_total++;
        if (gnt !== e.gnt) $display("FAIL single_gnt got=%b exp=%b", gnt, e.gnt); else n_pass++;
        n_total++;
        if (err !== e.err) $display("FAIL single_err got=%b exp=%b", err, e.err); else n_pass++;
        n_total++;
        if (q !== e.q) $display("FAIL single_q got=%h exp=%h", q, e.q); else n_pass++;
        n_total++;
        if (qb !== ~e.q) $display("FAIL single_qb got=%h exp=%h", qb, ~e.q); else n_pass++;
        @(posedge clk);
        #1;
        n_total++;
        if (gnt !== 4'b0000) $display("FAIL single_gnt_width got=%b exp=0000", gnt); else n_pass++;
        n_total++;
        if (busy !== 1'b0) $display("FAIL single_busy_done got=%b exp=0", busy); else n_pass++;
        n_total++;
        if (q !== e.q) $display("FAIL single_q_hold got=%h exp=%h", q, e.q); else n_pass++;
    endtask

    task automatic test_round_robin();
        exp_t e;
        bit   ok;
        int   cyc;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        m_q = 8'h00;
        m_ptr = 0;
        for (int i = 0; i < 4; i++) set_cmd(i, 1, 0, i);
        req = 4'hF;
        for (int n = 0; n < 5; n++) begin
            int w;
            w = rr_pick(req, m_ptr);
            push_exp(w, 1, 0, w);
        end
        for (int n = 0; n < 5; n++) begin
            wait_gnt(ok, cyc);
            n_total++;
            if (!ok) $display("FAIL rr_timeout grant=%0d got=none exp=grant", n); else n_pass++;
            if (sb.size() != 0) e = sb.pop_front();
            n_total++;
            if (gnt !== e.gnt) $display("FAIL rr_gnt grant=%0d got=%b exp=%b", n, gnt, e.gnt); else n_pass++;
            n_total++;
            if (q !== e.q) $display("FAIL rr_q grant=%0d got=%h exp=%h", n, q, e.q); else n_pass++;
            n_total++;
            if (cyc != ((n == 0) ? 2 : 3))
                $display("FAIL rr_spacing grant=%0d got=%0d exp=%0d", n, cyc, (n == 0) ? 2 : 3);
            else n_pass++;
        end
        @(negedge clk);
        req = 4'h0;
        repeat (3) @(posedge clk);
    endtask

    task automatic test_illegal();
        exp_t e;
        bit   ok;
        int   cyc;
        @(negedge clk);
        set_cmd(2, 1, 1, 1);
        req = 4'b0100;
        push_exp(rr_pick(req, m_ptr), 1, 1, 1);
        wait_gnt(ok, cyc);
        e = sb.pop_front();
        n_total++;
        if (gnt !== e.gnt) $display("FAIL illegal_gnt got=%b exp=%b", gnt, e.gnt); else n_pass++;
        n_total++;
        if (err !== e.err) $display("FAIL illegal_err got=%b exp=%b", err, e.err); else n_pass++;
        n_total++;
        if (q !== e.q) $display("FAIL illegal_q got=%h exp=%h", q, e.q); else n_pass++;
        @(negedge clk);
        req = 4'b0000;
        @(posedge clk);
        #1;
        n_total++;
        if (err !== 1'b0) $display("FAIL illegal_err_clear got=%b exp=0", err); else n_pass++;
        @(negedge clk);
        set_cmd(0, 1, 0, 7);
        set_cmd(3, 0, 1, 0);
        req = 4'b1001;
        begin
            int w;
            w = rr_pick(req, m_ptr);
            if (w == 3) push_exp(w, 0, 1, 0); else push_exp(w, 1, 0, 7);
            w = rr_pick(req, m_ptr);
            if (w == 3) push_exp(w, 0, 1, 0); else push_exp(w, 1, 0, 7);
        end
        for (int n = 0; n < 2; n++) begin
            wait_gnt(ok, cyc);
            n_total++;
            if (!ok) $display("FAIL after_err_timeout grant=%0d got=none exp=grant", n); else n_pass++;
            e = sb.pop_front();
            n_total++;
            if (gnt !== e.gnt) $display("FAIL after_err_gnt grant=%0d got=%b exp=%b", n, gnt, e.gnt); else n_pass++;
            n_total++;
            if (err !== e.err) $display("FAIL after_err_err grant=%0d got=%b exp=%b", n, err, e.err); else n_pass++;
            n_total++;
            if (q !== e.q) $display("FAIL after_err_q grant=%0d got=%h exp=%h", n, q, e.q); else n_pass++;
            @(negedge clk);
            req = req & ~gnt;
        end
        repeat (3) @(posedge clk);
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        set_cmd(1, 0, 1, 0);
        req = 4'b0010;
        @(posedge clk);
        #1;
        n_total++;
        if (busy !== 1'b1) $display("FAIL midrst_busy got=%b exp=1", busy); else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        req = 4'b0000;
        @(posedge clk);
        #1;
        n_total++;
        if (gnt !== 4'b0000) $display("FAIL midrst_gnt got=%b exp=0000", gnt); else n_pass++;
        n_total++;
        if (q !== 8'h00) $display("FAIL midrst_q got=%h exp=00", q); else n_pass++;
        n_total++;
        if (busy !== 1'b0) $display("FAIL midrst_busy_idle got=%b exp=0", busy); else n_pass++;
        @(negedge clk);
        rst = 1'b1;
        m_q = 8'h00;
        m_ptr = 0;
        @(posedge clk);
        #1;
        n_total++;
        if (gnt !== 4'b0000) $display("FAIL midrst_no_late_gnt got=%b exp=0000", gnt); else n_pass++;
    endtask

    task automatic test_noop_cmd();
        exp_t e;
        bit   ok;
        int   cyc;
        @(negedge clk);
        set_cmd(0, 0, 0, 2);
        set_cmd(1, 1, 0, 4);
        req = 4'b0011;
        begin
            int w;
            w = rr_pick(req, m_ptr);
            if (w == 0) push_exp(w, 0, 0, 2); else push_exp(w, 1, 0, 4);
            w = rr_pick(req, m_ptr);
            if (w == 0) push_exp(w, 0, 0, 2); else push_exp(w, 1, 0, 4);
        end
        for (int n = 0; n < 2; n++) begin
            wait_gnt(ok, cyc);
            n_total++;
            if (!ok) $display("FAIL noop_timeout grant=%0d got=none exp=grant", n); else n_pass++;
            e = sb.pop_front();
            n_total++;
            if (gnt !== e.gnt) $display("FAIL noop_gnt grant=%0d got=%b exp=%b", n, gnt, e.gnt); else n_pass++;
            n_total++;
            if (err !== e.err) $display("FAIL noop_err grant=%0d got=%b exp=%b", n, err, e.err); else n_pass++;
            n_total++;
            if (q !== e.q) $display("FAIL noop_q grant=%0d got=%h exp=%h", n, q, e.q); else n_pass++;
            @(negedge clk);
            req = req & ~gnt;
        end
        repeat (3) @(posedge clk);
    endtask

    task automatic test_small_bank();
        int   ti[3]   = '{2, 3, 0};
        bit   ts[3]   = '{1, 1, 1};
        bit   tr[3]   = '{0, 0, 0};
        int   tidx[3] = '{7, 6, 5};
        logic [5:0] m_q6;
        exp_t e;
        bit   ok;
        m_q6 = 6'h00;
        for (int n = 0; n < 3; n++) begin
            bit bad;
            logic [2:0] ix;
            @(negedge clk);
            ix = tidx[n][2:0];
            cmd_s6[ti[n]] = ts[n];
            cmd_r6[ti[n]] = tr[n];
            cmd_idx6[ti[n]*3 +: 3] = ix;
            req6 = 4'b0001 << ti[n];
            bad = (ts[n] && tr[n]) || (tidx[n] >= 6);
            if (!bad && ts[n]) m_q6[tidx[n]] = 1'b1;
            e.gnt = 4'b0001 << ti[n];
            e.err = bad;
            e.q   = {2'b00, m_q6};
            sb.push_back(e);
            ok = 1'b0;
            for (int c = 0; c < 8; c++) begin
                @(posedge clk);
                #1;
                if (gnt6 !== 4'b0000) begin
                    ok = 1'b1;
                    break;
                end
            end
            n_total++;
            if (!ok) $display("FAIL small_timeout cmd=%0d got=none exp=grant", n); else n_pass++;
            e = sb.pop_front();
            n_total++;
            if (gnt6 !== e.gnt) $display("FAIL small_gnt cmd=%0d got=%b exp=%b", n, gnt6, e.gnt); else n_pass++;
            n_total++;
            if (err6 !== e.err) $display("FAIL small_err cmd=%0d got=%b exp=%b", n, err6, e.err); else n_pass++;
            n_total++;
            if (q6 !== e.q[5:0]) $display("FAIL small_q cmd=%0d got=%h exp=%h", n, q6, e.q[5:0]); else n_pass++;
            @(negedge clk);
            req6 = 4'b0000;
            repeat (2) @(posedge clk);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_single_set();
        test_round_robin();
        test_illegal();
        test_reset_mid();
        test_noop_cmd();
        test_small_bank();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
